fabric_frac_slice: RTL and testbench

- Parametrised successor to the single fracturable logic element: N identical lanes, each with a K-input fracturable LUT, a 1-bit adder, two flip-flops and output muxes.
- Lane adders form a ripple carry chain from fabric_cin to fabric_cout.
- Configuration is held in an internal serial-load configuration shift register, controlled by a load FSM, instead of external memory ports.
- Sits inside the CLB in place of one fle/fabric instance; a cfg_sin/cfg_sout daisy chain links neighbouring slices.

---
 rtl/fabric_frac_slice_pkg.sv | 42 ++++
 rtl/fabric_frac_slice_lane.sv | 81 ++++++++
 rtl/fabric_frac_slice.sv | 124 ++++++++++++
 tb/tb_fabric_frac_slice.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fabric_frac_slice_pkg.sv
// fabric_frac_slice_pkg: shared types and per-lane configuration field layout
// for the fracturable fabric slice.
package fabric_frac_slice_pkg;

   // Configuration load state machine
   typedef enum logic [1:0] {
      UNCFG = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2
   } state_e;

   // out1 source select encoding
   localparam logic [1:0] OUT1_LUT1 = 2'd0;
   localparam logic [1:0] OUT1_SUM  = 2'd1;
   localparam logic [1:0] OUT1_FF1  = 2'd2;
   localparam logic [1:0] OUT1_ZERO = 2'd3;

   // Field offsets relative to the lane base, LSB first
   localparam int TT_OFS = 0;

   function automatic int frac_ofs(input int k);
      return (1 << k);
   endfunction

   function automatic int out0_ofs(input int k);
      return (1 << k) + 1;
   endfunction

   function automatic int out1_ofs(input int k);
      return (1 << k) + 2;
   endfunction

   function automatic int ffd1_ofs(input int k);
      return (1 << k) + 4;
   endfunction

   // Truth table plus frac, out0_sel, out1_sel[1:0], ffd1_sel
   function automatic int lane_cfg_w(input int k);
      return (1 << k) + 5;
   endfunction

endpackage

// File: rtl/fabric_frac_slice_lane.sv
// fabric_frac_slice_lane: one lane of the slice -- fracturable K-input LUT,
// one adder bit, two flip-flops and the output muxes.
module fabric_frac_slice_lane
   import fabric_frac_slice_pkg::*;
#(
   parameter int LUT_K      = 5,
   parameter int LANE_CFG_W = lane_cfg_w(LUT_K)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  run_i,
   input  logic                  ce_i,
   input  logic [LANE_CFG_W-1:0] cfg_i,
   input  logic [LUT_K-1:0]      in_i,
   input  logic                  cin_i,
   output logic                  cout_o,
   output logic                  out0_o,
   output logic                  out1_o
);

   localparam int TT_W = 1 << LUT_K;

   logic [TT_W-1:0] tt;
   logic            frac;
   logic            out0_sel;
   logic [1:0]      out1_sel;
   logic            ffd1_sel;
   logic            lut0;
   logic            lut1;
   logic            sum;
   logic            ff0_d;
   logic            ff1_d;
   logic            ff0_q;
   logic            ff1_q;

   assign tt       = cfg_i[TT_OFS +: TT_W];
   assign frac     = cfg_i[frac_ofs(LUT_K)];
   assign out0_sel = cfg_i[out0_ofs(LUT_K)];
   assign out1_sel = cfg_i[out1_ofs(LUT_K) +: 2];
   assign ffd1_sel = cfg_i[ffd1_ofs(LUT_K)];

   // LUT lookup: whole table, or two half tables sharing the low K-1 inputs
   always_comb begin
      lut0 = tt[in_i];
      lut1 = tt[in_i];
      if (frac) begin
         lut0 = tt[{1'b0, in_i[LUT_K-2:0]}];
         lut1 = tt[{1'b1, in_i[LUT_K-2:0]}];
      end
   end

   assign sum    = lut0 ^ lut1 ^ cin_i;
   assign cout_o = (lut0 & lut1) | (lut0 & cin_i) | (lut1 & cin_i);

   assign ff0_d = lut0;
   assign ff1_d = ffd1_sel ? sum : lut1;

   // Lane flip-flops: cleared outside RUN and on reload, load when enabled
   always_ff @(posedge clk_i) begin
      if (!rst_ni || !run_i) begin
         ff0_q <= 1'b0;
         ff1_q <= 1'b0;
      end else if (ce_i) begin
         ff0_q <= ff0_d;
         ff1_q <= ff1_d;
      end
   end

   // Output muxes
   always_comb begin
      out0_o = out0_sel ? ff0_q : lut0;
      unique case (out1_sel)
         OUT1_LUT1: out1_o = lut1;
         OUT1_SUM:  out1_o = sum;
         OUT1_FF1:  out1_o = ff1_q;
         OUT1_ZERO: out1_o = 1'b0;
         default:   out1_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/fabric_frac_slice.sv
// fabric_frac_slice: N fracturable logic lanes on a ripple carry chain, with a
// serially loaded configuration shift register and its load FSM.
// Optional macro FABRIC_FRAC_SLICE_CE_EN adds the fabric_ce clock-enable input.
module fabric_frac_slice
   import fabric_frac_slice_pkg::*;
#(
   parameter int LUT_K      = 5,
   parameter int NUM_LANES  = 2,
   parameter int LANE_CFG_W = lane_cfg_w(LUT_K),
   parameter int CFG_W      = NUM_LANES * LANE_CFG_W
) (
   input  logic                         fabric_clk,
   input  logic                         fabric_reset,
   input  logic [NUM_LANES*LUT_K-1:0]   fabric_in,
   input  logic                         fabric_cin,
`ifdef FABRIC_FRAC_SLICE_CE_EN
   input  logic                         fabric_ce,
`endif
   input  logic                         cfg_en,
   input  logic                         cfg_sin,
   output logic                         cfg_sout,
   output logic                         cfg_done,
   output logic                         fabric_cout,
   output logic [2*NUM_LANES-1:0]       fabric_out
);

   localparam int CNT_W = $clog2(CFG_W + 1);

   state_e                 state_q;
   state_e                 state_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic [CFG_W-1:0]       cfg_q;
   logic                   sout_q;
   logic                   run;
   logic                   lane_run;
   logic                   ce;
   logic [NUM_LANES:0]     carry;
   logic [2*NUM_LANES-1:0] lane_out;

`ifdef FABRIC_FRAC_SLICE_CE_EN
   assign ce = fabric_ce;
`else
   assign ce = 1'b1;
`endif

   // Load FSM next state: any cfg_en outside LOAD starts a fresh load
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         UNCFG, RUN: begin
            if (cfg_en) begin
               state_d = LOAD;
               cnt_d   = CNT_W'(1);
            end
         end
         LOAD: begin
            if (cfg_en) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_d == CNT_W'(CFG_W)) begin
                  state_d = RUN;
               end
            end
         end
         default: begin
            state_d = UNCFG;
            cnt_d   = '0;
         end
      endcase
   end

   // Load FSM state and bit counter
   always_ff @(posedge fabric_clk) begin
      if (!fabric_reset) begin
         state_q <= UNCFG;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Configuration shift register; the bit shifted out feeds the next slice
   always_ff @(posedge fabric_clk) begin
      if (!fabric_reset) begin
         cfg_q  <= '0;
         sout_q <= 1'b0;
      end else if (cfg_en) begin
         cfg_q  <= {cfg_sin, cfg_q[CFG_W-1:1]};
         sout_q <= cfg_q[0];
      end
   end

   assign run = (state_q == RUN);
   // Lane flops also clear on the edge that starts a reload from RUN
   assign lane_run = run & ~cfg_en;

   assign carry[0] = fabric_cin;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      fabric_frac_slice_lane #(
         .LUT_K      (LUT_K),
         .LANE_CFG_W (LANE_CFG_W)
      ) u_lane (
         .clk_i  (fabric_clk),
         .rst_ni (fabric_reset),
         .run_i  (lane_run),
         .ce_i   (ce),
         .cfg_i  (cfg_q[i*LANE_CFG_W +: LANE_CFG_W]),
         .in_i   (fabric_in[i*LUT_K +: LUT_K]),
         .cin_i  (carry[i]),
         .cout_o (carry[i+1]),
         .out0_o (lane_out[2*i]),
         .out1_o (lane_out[2*i+1])
      );
   end

   assign fabric_out  = run ? lane_out : '0;
   assign fabric_cout = run & carry[NUM_LANES];
   assign cfg_done    = run;
   assign cfg_sout    = sout_q;

endmodule

// File: tb/tb_fabric_frac_slice.sv
// tb_fabric_frac_slice: directed-vector bench for fabric_frac_slice (K=5, N=2).
// Build with FABRIC_FRAC_SLICE_CE_EN defined to exercise the fabric_ce port.
module tb_fabric_frac_slice;

   localparam int K     = 5;
   localparam int N     = 2;
   localparam int CFG_W = 74;

   // Lane fields, MSB first: ffd1_sel, out1_sel[1:0], out0_sel, frac, tt[31:0]
   // Adder mode: low half tt = in0, high half tt = in1, out1 = sum
   localparam logic [36:0] LANE_A = {1'b0, 2'b01, 1'b0, 1'b1, 32'hCCCC_AAAA};
   // Registered mode: tt all ones, out0 = ff0, out1 = ff1, ff1 takes sum
   localparam logic [36:0] LANE_R = {1'b1, 2'b10, 1'b1, 1'b0, 32'hFFFF_FFFF};
   localparam logic [CFG_W-1:0] CFG_A = {LANE_A, LANE_A};
   localparam logic [CFG_W-1:0] CFG_R = {LANE_R, LANE_R};

   logic             fabric_clk;
   logic             fabric_reset;
   logic [N*K-1:0]   fabric_in;
   logic             fabric_cin;
   logic             fabric_ce;
   logic             cfg_en;
   logic             cfg_sin;
   logic             cfg_sout;
   logic             cfg_done;
   logic             fabric_cout;
   logic [2*N-1:0]   fabric_out;

   int n_checks;
   int n_errors;

   // Adder-mode vectors: {lane1 in, lane0 in}, cin, expected out, expected cout
   logic [9:0] av_in   [5];
   logic       av_cin  [5];
   logic [3:0] av_out  [5];
   logic       av_cout [5];

   fabric_frac_slice #(
      .LUT_K     (K),
      .NUM_LANES (N)
   ) dut (
      .fabric_clk   (fabric_clk),
      .fabric_reset (fabric_reset),
      .fabric_in    (fabric_in),
      .fabric_cin   (fabric_cin),
`ifdef FABRIC_FRAC_SLICE_CE_EN
      .fabric_ce    (fabric_ce),
`endif
      .cfg_en       (cfg_en),
      .cfg_sin      (cfg_sin),
      .cfg_sout     (cfg_sout),
      .cfg_done     (cfg_done),
      .fabric_cout  (fabric_cout),
      .fabric_out   (fabric_out)
   );

   initial fabric_clk = 1'b0;
   always #5 fabric_clk = ~fabric_clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge fabric_clk);
      #1;
   endtask

   // Shift a full configuration, optionally pausing ngaps cycles at bit gap_at
   task automatic load_cfg(input logic [CFG_W-1:0] cfg, input int gap_at,
                           input int ngaps, input logic exp_sout1);
      int sent;
      int gaps;
      int edges;
      sent  = 0;
      gaps  = 0;
      edges = 0;
      while (sent < CFG_W) begin
         if (sent == gap_at && gaps < ngaps) begin
            cfg_en = 1'b0;
         end else begin
            cfg_en  = 1'b1;
            cfg_sin = cfg[sent];
         end
         tick();
         edges++;
         if (cfg_en) sent++;
         else        gaps++;
         if (edges == 1) begin
            chk("load_first_out", 32'(fabric_out), 32'h0);
            chk("load_first_sout", 32'(cfg_sout), 32'(exp_sout1));
         end
         if (sent < CFG_W) chk("load_done_early", 32'(cfg_done), 32'h0);
      end
      cfg_en = 1'b0;
      chk("load_done", 32'(cfg_done), 32'h1);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;

      av_in[0] = {5'b00000, 5'b00011}; av_cin[0] = 1'b1; av_out[0] = 4'b1011; av_cout[0] = 1'b0;
      av_in[1] = {5'b00011, 5'b00001}; av_cin[1] = 1'b0; av_out[1] = 4'b0111; av_cout[1] = 1'b1;
      av_in[2] = {5'b00010, 5'b00011}; av_cin[2] = 1'b0; av_out[2] = 4'b0001; av_cout[2] = 1'b1;
      av_in[3] = {5'b10010, 5'b10001}; av_cin[3] = 1'b0; av_out[3] = 4'b1011; av_cout[3] = 1'b0;
      av_in[4] = {5'b00000, 5'b00000}; av_cin[4] = 1'b0; av_out[4] = 4'b0000; av_cout[4] = 1'b0;

      // Reset with random inputs and cfg_en held high
      fabric_reset = 1'b0;
      fabric_in    = 10'($urandom);
      fabric_cin   = 1'($urandom);
      fabric_ce    = 1'b1;
      cfg_en       = 1'b1;
      cfg_sin      = 1'($urandom);
      tick();
      tick();
      chk("rst_out", 32'(fabric_out), 32'h0);
      chk("rst_cout", 32'(fabric_cout), 32'h0);
      chk("rst_done", 32'(cfg_done), 32'h0);
      chk("rst_sout", 32'(cfg_sout), 32'h0);
      fabric_reset = 1'b1;
      cfg_en       = 1'b0;
      tick();
      chk("uncfg_idle_done", 32'(cfg_done), 32'h0);

      // Registered-path configuration, no gaps
      fabric_cin = 1'b0;
      load_cfg(CFG_R, -1, 0, 1'b0);
      chk("load_sout_old", 32'(cfg_sout), 32'h0);
      chk("reg_first_out", 32'(fabric_out), 32'h0);
      chk("reg_first_cout", 32'(fabric_cout), 32'h1);
      tick();
      chk("reg_second_out", 32'(fabric_out), 32'b1101);
      fabric_cin = 1'b1;
      #1;
      chk("reg_hold_out", 32'(fabric_out), 32'b1101);
      tick();
      chk("reg_sum1_out", 32'(fabric_out), 32'b1111);
      fabric_cin = 1'b0;
      tick();
      chk("reg_sum0_out", 32'(fabric_out), 32'b1101);

`ifdef FABRIC_FRAC_SLICE_CE_EN
      // Clock enable low: D toggles, Q holds
      fabric_ce = 1'b0;
      for (int i = 0; i < 3; i++) begin
         fabric_cin = ~fabric_cin;
         tick();
         chk("ce_hold_out", 32'(fabric_out), 32'b1101);
      end
      fabric_ce = 1'b1;
      tick();
      chk("ce_update_out", 32'(fabric_out), 32'b1111);
      fabric_cin = 1'b0;
`endif

      // Reconfigure from RUN to adder mode with 5 pause cycles mid-load;
      // the first shift pushes out the first bit of the previous load
      load_cfg(CFG_A, 30, 5, 1'b1);

      for (int v = 0; v < 5; v++) begin
         fabric_in  = av_in[v];
         fabric_cin = av_cin[v];
         #1;
         chk($sformatf("add_out_v%0d", v), 32'(fabric_out), 32'(av_out[v]));
         chk($sformatf("add_cout_v%0d", v), 32'(fabric_cout), 32'(av_cout[v]));
      end

      // Reset at bit 30 of a load aborts it
      cfg_en = 1'b1;
      for (int i = 0; i < 30; i++) begin
         cfg_sin = CFG_R[i];
         tick();
      end
      fabric_reset = 1'b0;
      tick();
      chk("abort_done", 32'(cfg_done), 32'h0);
      chk("abort_out", 32'(fabric_out), 32'h0);
      chk("abort_sout", 32'(cfg_sout), 32'h0);
      fabric_reset = 1'b1;
      cfg_en       = 1'b0;
      tick();
      chk("abort_idle_done", 32'(cfg_done), 32'h0);

      // Counter and register restarted from zero: a full-length load completes
      load_cfg(CFG_A, -1, 0, 1'b0);
      fabric_in  = av_in[0];
      fabric_cin = av_cin[0];
      #1;
      chk("reload_out", 32'(fabric_out), 32'(av_out[0]));
      chk("reload_cout", 32'(fabric_cout), 32'(av_cout[0]));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
